// File: rtl/robot_arm_cordic.sv
// robot_arm_cordic: 3-DOF forward kinematics (base yaw, shoulder, elbow).
// One iterative CORDIC rotator is shared by three rotations: the shoulder link,
// the forearm link, and the resulting horizontal reach about the base axis.
module robot_arm_cordic #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int FRAC_BITS      = 14,
  parameter int ITER           = 16,
  parameter int A1             = 20,
  parameter int A2             = 10,
  parameter int B              = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_thi_valid,
  output logic                      o_thi_ready,
  input  logic [DATA_WIDTH_IN-1:0]  i_thi1,
  input  logic [DATA_WIDTH_IN-1:0]  i_thi2,
  input  logic [DATA_WIDTH_IN-1:0]  i_thi3,
  output logic                      o_xyz_valid,
  output logic [DATA_WIDTH_OUT-1:0] o_x,
  output logic [DATA_WIDTH_OUT-1:0] o_y,
  output logic [DATA_WIDTH_OUT-1:0] o_z
);

  localparam int W  = DATA_WIDTH_OUT + 2;
  localparam int AW = DATA_WIDTH_IN + 2;
  localparam int CW = $clog2(ITER);

  // K^-1 in Q16; link lengths are pre-scaled by it so the CORDIC gain cancels
  localparam longint KINV_Q16 = 39797;
  localparam logic signed [W-1:0] L1 =
    W'((longint'(A1) * (longint'(1) << FRAC_BITS) * KINV_Q16) >>> 16);
  localparam logic signed [W-1:0] L2 =
    W'((longint'(A2) * (longint'(1) << FRAC_BITS) * KINV_Q16) >>> 16);
  localparam logic signed [W-1:0] ZB = W'(longint'(B) << FRAC_BITS);
  localparam logic signed [AW-1:0] QTR = AW'(longint'(1) << (DATA_WIDTH_IN - 2));
  localparam logic signed [17:0] KINV_MUL = 18'sd39797;

  function automatic logic signed [AW-1:0] atan_entry(input int unsigned i);
    real v;
    v = $atan(1.0 / (2.0 ** i)) * (2.0 ** DATA_WIDTH_IN) / (2.0 * 3.141592653589793);
    return AW'($rtoi(v + 0.5));
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD1, S_ROT1, S_LOAD2, S_ROT2, S_LOAD3, S_ROT3, S_OUT
  } state_t;

  state_t r_state, w_next;

  logic                      r_ready, r_valid;
  logic [CW-1:0]             r_iter;
  logic [DATA_WIDTH_IN-1:0]  r_th1, r_th2, r_th3;
  logic signed [W-1:0]       r_x, r_y, r_c1, r_s1, r_zout;
  logic signed [AW-1:0]      r_z;
  logic [DATA_WIDTH_OUT-1:0] r_ox, r_oy, r_oz;

  logic                      w_accept, w_load, w_rot, w_last, w_fire;
  logic [DATA_WIDTH_IN-1:0]  w_ld_ang;
  logic signed [AW-1:0]      w_ld_ang_s;
  logic signed [W-1:0]       w_ld_len, w_ld_x, w_ld_y;
  logic signed [AW-1:0]      w_ld_z;
  logic signed [W-1:0]       w_r, w_zsum, w_rk;
  logic signed [W+17:0]      w_prod;
  logic signed [AW-1:0]      w_atan_tab [ITER];
  logic signed [AW-1:0]      w_atan, w_zn;
  logic signed [W-1:0]       w_xs, w_ys, w_xn, w_yn;

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic signed [AW-1:0] ATAN_G = atan_entry(g);
    assign w_atan_tab[g] = ATAN_G;
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state sequencing through the three rotations
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_LOAD1;
      S_LOAD1: w_next = S_ROT1;
      S_ROT1:  if (w_last) w_next = S_LOAD2;
      S_LOAD2: w_next = S_ROT2;
      S_ROT2:  if (w_last) w_next = S_LOAD3;
      S_LOAD3: w_next = S_ROT3;
      S_ROT3:  if (w_last) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // state decode for the datapath
  always_comb begin
    w_accept = (r_state == S_IDLE) && i_thi_valid && r_ready;
    w_load   = (r_state == S_LOAD1) || (r_state == S_LOAD2) || (r_state == S_LOAD3);
    w_rot    = (r_state == S_ROT1) || (r_state == S_ROT2) || (r_state == S_ROT3);
    w_last   = (r_iter == CW'(ITER - 1));
    w_fire   = (r_state == S_ROT3) && w_last;
  end

  // reach/height combination and r*K^-1 rescale for the base rotation
  always_comb begin
    w_r    = r_c1 + r_x;
    w_zsum = ZB + r_s1 + r_y;
    w_prod = (W+18)'(w_r) * (W+18)'(KINV_MUL);
    w_rk   = W'(w_prod >>> 16);
  end

  // load vector selection and quadrant fold into the CORDIC convergence range
  always_comb begin
    w_ld_ang = r_th1;
    w_ld_len = w_rk;
    case (r_state)
      S_LOAD1: begin w_ld_ang = r_th2;         w_ld_len = L1; end
      S_LOAD2: begin w_ld_ang = r_th2 + r_th3; w_ld_len = L2; end
      default: begin w_ld_ang = r_th1;         w_ld_len = w_rk; end
    endcase
    w_ld_ang_s = {{2{w_ld_ang[DATA_WIDTH_IN-1]}}, w_ld_ang};
    case (w_ld_ang[DATA_WIDTH_IN-1 -: 2])
      2'b01: begin w_ld_x = '0; w_ld_y = w_ld_len;  w_ld_z = w_ld_ang_s - QTR; end
      2'b10: begin w_ld_x = '0; w_ld_y = -w_ld_len; w_ld_z = w_ld_ang_s + QTR; end
      default: begin w_ld_x = w_ld_len; w_ld_y = '0; w_ld_z = w_ld_ang_s; end
    endcase
  end

  // one CORDIC micro-rotation driving the residual angle towards zero
  always_comb begin
    w_atan = w_atan_tab[r_iter];
    w_xs   = r_x >>> r_iter;
    w_ys   = r_y >>> r_iter;
    if (!r_z[AW-1]) begin
      w_xn = r_x - w_ys;
      w_yn = r_y + w_xs;
      w_zn = r_z - w_atan;
    end else begin
      w_xn = r_x + w_ys;
      w_yn = r_y - w_xs;
      w_zn = r_z + w_atan;
    end
  end

  // datapath, handshake and result registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_iter  <= '0;
      r_th1   <= '0;
      r_th2   <= '0;
      r_th3   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_c1    <= '0;
      r_s1    <= '0;
      r_zout  <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_oz    <= '0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_valid <= w_fire;
      if (w_accept) begin
        r_th1 <= i_thi1;
        r_th2 <= i_thi2;
        r_th3 <= i_thi3;
      end
      if (w_load) begin
        r_iter <= '0;
        r_x    <= w_ld_x;
        r_y    <= w_ld_y;
        r_z    <= w_ld_z;
      end else if (w_rot) begin
        r_iter <= r_iter + CW'(1);
        r_x    <= w_xn;
        r_y    <= w_yn;
        r_z    <= w_zn;
      end
      if (r_state == S_LOAD2) begin
        r_c1 <= r_x;
        r_s1 <= r_y;
      end
      if (r_state == S_LOAD3) r_zout <= w_zsum;
      // results are captured on the final micro-rotation so the strobe lines up with OUT
      if (w_fire) begin
        r_ox <= DATA_WIDTH_OUT'(w_xn);
        r_oy <= DATA_WIDTH_OUT'(w_yn);
        r_oz <= DATA_WIDTH_OUT'(r_zout);
      end
    end
  end

  assign o_thi_ready = r_ready;
  assign o_xyz_valid = r_valid;
  assign o_x         = r_ox;
  assign o_y         = r_oy;
  assign o_z         = r_oz;

endmodule
